// File: rtl/wordle_pkg.sv
// Shared constants, encodings and small helpers for the wordle board and its scorer.
package wordle_pkg;

  localparam int ROWS   = 6;
  localparam int COLS   = 5;
  localparam int CELL_W = 7;
  localparam int CHAR_W = 5;
  localparam int DISP_W = ROWS * COLS * CELL_W;

  typedef enum logic [1:0] {
    CLR_NONE   = 2'd0,
    CLR_GREEN  = 2'd1,
    CLR_YELLOW = 2'd2,
    CLR_GRAY   = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    KEY_LETTER = 2'd0,
    KEY_BACK   = 2'd1,
    KEY_ENTER  = 2'd2,
    KEY_NONE   = 2'd3
  } key_cmd_e;

  typedef enum logic [1:0] {
    GS_NOGAME  = 2'd0,
    GS_PLAYING = 2'd1,
    GS_WON     = 2'd2,
    GS_LOST    = 2'd3
  } game_st_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YEL0   = 3'd2,
    ST_YEL1   = 3'd3,
    ST_YEL2   = 3'd4,
    ST_YEL3   = 3'd5,
    ST_YEL4   = 3'd6,
    ST_COMMIT = 3'd7
  } ctrl_st_e;

  localparam logic [9:0] ALL_GREEN = 10'b01_01_01_01_01;

  function automatic logic letter_ok(input logic [4:0] code);
    return (code >= 5'd1) && (code <= 5'd26);
  endfunction

endpackage

// File: rtl/wordle_scorer.sv
// Multi-cycle guess scorer: one exact-match pass on start, then one
// misplaced-letter pass per guess position, lowest free target slot first.
module wordle_scorer
  import wordle_pkg::*;
(
  input  logic        dclk,
  input  logic        clr,
  input  logic        abort,
  input  logic        start,
  input  logic [24:0] guess,
  input  logic [24:0] tgt,
  output logic [9:0]  colors,
  output logic        done
);

  logic [9:0] colors_q, colors_d;
  logic [4:0] used_q, used_d;
  logic [2:0] idx_q, idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       found_s;

  // Next-state for the green pass and the per-position yellow passes.
  always_comb begin
    colors_d = colors_q;
    used_d   = used_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_s  = 1'b0;
    if (abort) begin
      colors_d = 10'd0;
      used_d   = 5'd0;
      idx_d    = 3'd0;
      busy_d   = 1'b0;
    end else if (start) begin
      for (int p = 0; p < COLS; p++) begin
        if (guess[CHAR_W*p +: CHAR_W] == tgt[CHAR_W*p +: CHAR_W]) begin
          colors_d[2*p +: 2] = CLR_GREEN;
          used_d[p]          = 1'b1;
        end else begin
          colors_d[2*p +: 2] = CLR_NONE;
          used_d[p]          = 1'b0;
        end
      end
      idx_d  = 3'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      for (int p = 0; p < COLS; p++) begin
        if ((idx_q == 3'(p)) && (colors_q[2*p +: 2] != CLR_GREEN)) begin
          // Only the first free matching slot is claimed.
          for (int j = 0; j < COLS; j++) begin
            if (!found_s && !used_q[j] &&
                (tgt[CHAR_W*j +: CHAR_W] == guess[CHAR_W*p +: CHAR_W])) begin
              found_s   = 1'b1;
              used_d[j] = 1'b1;
            end else begin
              used_d[j] = used_d[j];
            end
          end
          colors_d[2*p +: 2] = found_s ? CLR_YELLOW : CLR_GRAY;
        end else begin
          colors_d[2*p +: 2] = colors_d[2*p +: 2];
        end
      end
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'd4) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Scorer state registers.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      colors_q <= 10'd0;
      used_q   <= 5'd0;
      idx_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      colors_q <= colors_d;
      used_q   <= used_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign colors = colors_q;
  assign done   = done_q;

endmodule

// File: rtl/wordle_board.sv
// Wordle game board: key entry, row scoring sequence and game status,
// with the whole 6x5 board exposed as a registered display vector.
module wordle_board
  import wordle_pkg::*;
(
  input  logic         dclk,
  input  logic         clr,
  input  logic         new_game,
  input  logic [24:0]  target,
  input  logic         key_valid,
  input  logic [1:0]   key_cmd,
  input  logic [4:0]   key_code,
  output logic         key_ready,
  output logic [209:0] display,
  output logic [1:0]   game_st,
  output logic [2:0]   cur_row,
  output logic [2:0]   cur_col,
  output logic         guess_done
);

  logic [DISP_W-1:0] display_q, display_d;
  logic [24:0]       tgt_q, tgt_d;
  logic [2:0]        cur_row_q, cur_row_d;
  logic [2:0]        cur_col_q, cur_col_d;
  game_st_e          game_q, game_d;
  ctrl_st_e          state_q, state_d;
  logic              guess_done_q, guess_done_d;
  logic              key_ready_q, key_ready_d;

  logic [24:0]       guess_s;
  logic [9:0]        sc_colors_s;
  logic              sc_done_s;
  logic              sc_start_s;

  assign sc_start_s = (state_q == ST_GREEN);

  wordle_scorer u_scorer (
    .dclk   (dclk),
    .clr    (clr),
    .abort  (new_game),
    .start  (sc_start_s),
    .guess  (guess_s),
    .tgt    (tgt_q),
    .colors (sc_colors_s),
    .done   (sc_done_s)
  );

  // Letters of the active row, fed to the scorer.
  always_comb begin
    guess_s = 25'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (cur_row_q == 3'(r)) begin
        for (int c = 0; c < COLS; c++) begin
          guess_s[CHAR_W*c +: CHAR_W] = display_q[CELL_W*(r*COLS+c) +: CHAR_W];
        end
      end else begin
        guess_s = guess_s;
      end
    end
  end

  // Controller next-state: new_game overrides everything, then key handling or scoring.
  always_comb begin
    display_d    = display_q;
    tgt_d        = tgt_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    game_d       = game_q;
    state_d      = state_q;
    guess_done_d = 1'b0;
    if (new_game) begin
      display_d = {DISP_W{1'b0}};
      tgt_d     = target;
      cur_row_d = 3'd0;
      cur_col_d = 3'd0;
      game_d    = GS_PLAYING;
      state_d   = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid && key_ready_q) begin
            case (key_cmd_e'(key_cmd))
              KEY_LETTER: begin
                if (letter_ok(key_code) && (cur_col_q < 3'd5)) begin
                  for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                      if ((cur_row_q == 3'(r)) && (cur_col_q == 3'(c))) begin
                        display_d[CELL_W*(r*COLS+c) +: CELL_W] = {2'b00, key_code};
                      end else begin
                        display_d = display_d;
                      end
                    end
                  end
                  cur_col_d = cur_col_q + 3'd1;
                end else begin
                  cur_col_d = cur_col_q;
                end
              end
              KEY_BACK: begin
                if (cur_col_q != 3'd0) begin
                  for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                      if ((cur_row_q == 3'(r)) && (cur_col_q == 3'(c + 1))) begin
                        display_d[CELL_W*(r*COLS+c) +: CELL_W] = 7'd0;
                      end else begin
                        display_d = display_d;
                      end
                    end
                  end
                  cur_col_d = cur_col_q - 3'd1;
                end else begin
                  cur_col_d = cur_col_q;
                end
              end
              KEY_ENTER: begin
                if (cur_col_q == 3'd5) begin
                  state_d = ST_GREEN;
                end else begin
                  state_d = ST_IDLE;
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_GREEN: state_d = ST_YEL0;
        ST_YEL0:  state_d = ST_YEL1;
        ST_YEL1:  state_d = ST_YEL2;
        ST_YEL2:  state_d = ST_YEL3;
        ST_YEL3:  state_d = ST_YEL4;
        ST_YEL4:  state_d = ST_COMMIT;
        ST_COMMIT: begin
          if (sc_done_s) begin
            for (int r = 0; r < ROWS; r++) begin
              if (cur_row_q == 3'(r)) begin
                for (int c = 0; c < COLS; c++) begin
                  display_d[CELL_W*(r*COLS+c) + CHAR_W +: 2] = sc_colors_s[2*c +: 2];
                end
              end else begin
                display_d = display_d;
              end
            end
            if (sc_colors_s == ALL_GREEN) begin
              game_d = GS_WON;
            end else if (cur_row_q == 3'd5) begin
              game_d = GS_LOST;
            end else begin
              game_d = game_q;
            end
            guess_done_d = 1'b1;
            cur_row_d    = cur_row_q + 3'd1;
            cur_col_d    = 3'd0;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_COMMIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    key_ready_d = (game_d == GS_PLAYING) && (state_d == ST_IDLE);
  end

  // Board, status and controller state registers.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      display_q    <= {DISP_W{1'b0}};
      tgt_q        <= 25'd0;
      cur_row_q    <= 3'd0;
      cur_col_q    <= 3'd0;
      game_q       <= GS_NOGAME;
      state_q      <= ST_IDLE;
      guess_done_q <= 1'b0;
      key_ready_q  <= 1'b0;
    end else begin
      display_q    <= display_d;
      tgt_q        <= tgt_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      game_q       <= game_d;
      state_q      <= state_d;
      guess_done_q <= guess_done_d;
      key_ready_q  <= key_ready_d;
    end
  end

  assign display    = display_q;
  assign game_st    = game_q;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;
  assign guess_done = guess_done_q;
  assign key_ready  = key_ready_q;

endmodule
